i2s_receiver: RTL and testbench

Philips-I2S serial audio receiver. Samples a serial bit stream on the bit clock and deserialises left and right channel words (MSB first) into parallel outputs of configurable width. Delivers each completed stereo pair as a registered pair plus a one-cycle strobe, for downstream sample-rate logic clocked by the same bit clock.

---
 rtl/i2s_receiver.sv | 120 ++++++++++++
 tb/tb_i2s_receiver.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/i2s_receiver.sv
// Philips-I2S receiver: deserialises MSB-first left/right words on rising sck
// and presents each complete stereo pair with a one-cycle ock strobe.
module i2s_receiver #(
  parameter int unsigned b = 16
) (
  input  logic         sck,
  input  logic         rst,
  input  logic         ws,
  input  logic         sd,
  output logic [b-1:0] l,
  output logic [b-1:0] r,
  output logic         ock
);

  localparam int unsigned CW = $clog2(b + 1);

  typedef enum logic {
    ST_HUNT,
    ST_SYNCED
  } state_t;

  state_t          state_q, state_d;
  logic            ws_q, ws_d;
  logic [b-1:0]    buf_q, buf_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [b-1:0]    lhold_q, lhold_d;
  logic            lvalid_q, lvalid_d;
  logic [b-1:0]    l_q, l_d;
  logic [b-1:0]    r_q, r_d;
  logic            ock_q, ock_d;

  logic            trans;
  logic [b-1:0]    buf_fill;
  logic [CW-1:0]   cnt_fill;

  always_comb begin
    state_d  = state_q;
    ws_d     = ws;
    buf_d    = buf_q;
    cnt_d    = cnt_q;
    lhold_d  = lhold_q;
    lvalid_d = lvalid_q;
    l_d      = l_q;
    r_d      = r_q;
    ock_d    = 1'b0;

    trans    = (ws != ws_q);

    // Store the sampled bit until the counter saturates; later bits are dropped.
    buf_fill = buf_q;
    cnt_fill = cnt_q;
    for (int unsigned i = 0; i < b; i++) begin
      if (CW'(i) == cnt_q) begin
        buf_fill[b-1-i] = sd;
      end
    end
    if (cnt_q != CW'(b)) begin
      cnt_fill = cnt_q + CW'(1);
    end

    unique case (state_q)
      ST_HUNT: begin
        if (trans && ws_q && !ws) begin
          state_d = ST_SYNCED;
          buf_d   = '0;
          cnt_d   = '0;
        end
      end
      ST_SYNCED: begin
        buf_d = buf_fill;
        cnt_d = cnt_fill;
        if (trans) begin
          if (!ws_q) begin
            lhold_d  = buf_fill;
            lvalid_d = 1'b1;
          end else begin
            if (lvalid_q) begin
              l_d   = lhold_q;
              r_d   = buf_fill;
              ock_d = 1'b1;
            end
            lvalid_d = 1'b0;
          end
          buf_d = '0;
          cnt_d = '0;
        end
      end
      default: state_d = ST_HUNT;
    endcase
  end

  always_ff @(posedge sck) begin
    if (rst) begin
      state_q  <= ST_HUNT;
      ws_q     <= 1'b0;
      buf_q    <= '0;
      cnt_q    <= '0;
      lhold_q  <= '0;
      lvalid_q <= 1'b0;
      l_q      <= '0;
      r_q      <= '0;
      ock_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ws_q     <= ws_d;
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      lhold_q  <= lhold_d;
      lvalid_q <= lvalid_d;
      l_q      <= l_d;
      r_q      <= r_d;
      ock_q    <= ock_d;
    end
  end

  assign l   = l_q;
  assign r   = r_q;
  assign ock = ock_q;

endmodule

// File: tb/tb_i2s_receiver.sv
// Bench for i2s_receiver: directed I2S frames plus random slot lengths, checked
// every cycle against a queue-based model of the serial stream.
module tb_i2s_receiver;

  localparam int unsigned B = 5;

  logic         sck = 1'b0;
  logic         rst = 1'b1;
  logic         ws  = 1'b0;
  logic         sd  = 1'b0;
  logic [B-1:0] l;
  logic [B-1:0] r;
  logic         ock;

  int checks = 0;
  int errors = 0;

  i2s_receiver #(.b(B)) dut (
    .sck (sck),
    .rst (rst),
    .ws  (ws),
    .sd  (sd),
    .l   (l),
    .r   (r),
    .ock (ock)
  );

  always #5 sck = ~sck;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: bits of the current slot in arrival order; a word is
  // its first B bits, zero-filled when the slot is short.
  bit           m_prev, m_sync, m_lvalid;
  bit           slot[$];
  logic [B-1:0] m_lhold;
  logic [B-1:0] exp_l, exp_r;
  logic         exp_ock;
  int           pulses = 0;
  logic [B-1:0] got_l, got_r;

  always @(posedge sck) begin
    logic [B-1:0] w;
    if (rst) begin
      m_prev   = 1'b0;
      m_sync   = 1'b0;
      m_lvalid = 1'b0;
      m_lhold  = '0;
      slot.delete();
      exp_l    = '0;
      exp_r    = '0;
      exp_ock  = 1'b0;
    end else begin
      exp_ock = 1'b0;
      if (m_sync) slot.push_back(sd);
      if (ws != m_prev) begin
        if (m_sync) begin
          w = '0;
          for (int i = 0; i < slot.size() && i < int'(B); i++) w[int'(B)-1-i] = slot[i];
          if (!m_prev) begin
            m_lhold  = w;
            m_lvalid = 1'b1;
          end else begin
            if (m_lvalid) begin
              exp_l   = m_lhold;
              exp_r   = w;
              exp_ock = 1'b1;
            end
            m_lvalid = 1'b0;
          end
          slot.delete();
        end else if (m_prev && !ws) begin
          m_sync = 1'b1;
        end
      end
      m_prev = ws;
    end
    #1;
    check("ock", ock, exp_ock);
    check("l", l, exp_l);
    check("r", r, exp_r);
    if (ock === 1'b1) begin
      pulses++;
      got_l = l;
      got_r = r;
    end
  end

  logic carry = 1'b0;

  task automatic tick(input logic w_s, input logic d);
    @(negedge sck);
    ws = w_s;
    sd = d;
  endtask

  // One slot of n sck cycles; the first cycle carries the previous word's LSB.
  task automatic send_word(input logic ch, input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) tick(ch, (i == 0) ? carry : w[n-i]);
    carry = w[0];
  endtask

  task automatic do_reset(input int cyc);
    for (int i = 0; i < cyc; i++) begin
      @(negedge sck);
      rst = 1'b1;
      ws  = 1'($urandom);
      sd  = 1'($urandom);
    end
    @(negedge sck);
    rst   = 1'b0;
    ws    = 1'b0;
    sd    = 1'b0;
    carry = 1'b0;
    check("rst_l", l, 0);
    check("rst_r", r, 0);
    check("rst_ock", ock, 0);
  endtask

  task automatic pair_test(input string tag, input logic [31:0] lw, input logic [31:0] rw,
                           input int n, input logic [B-1:0] el, input logic [B-1:0] er);
    int p0;
    do_reset(2);
    p0 = pulses;
    send_word(1'b1, 0, 2);
    send_word(1'b0, lw, n);
    send_word(1'b1, rw, n);
    send_word(1'b0, 0, 3);
    check({tag, "_pulses"}, pulses - p0, 1);
    check({tag, "_l"}, got_l, el);
    check({tag, "_r"}, got_r, er);
  endtask

  initial begin
    int          p0;
    logic [7:0]  pat;

    do_reset(2);

    pair_test("exact", 32'b10110, 32'b01101, 5, 5'b10110, 5'b01101);
    pair_test("long", 32'b1011011, 32'b0110100, 7, 5'b10110, 5'b01101);
    pair_test("short", 32'b101, 32'b011, 3, 5'b10100, 5'b01100);

    // Continuous stream: ws toggles every 7 sck, repeating sd pattern.
    do_reset(2);
    p0  = pulses;
    pat = 8'b01110110;
    for (int c = 0; c < 45; c++) tick(((c / 7) % 2) == 1, pat[7 - (c % 8)]);
    check("stream_pulses", pulses - p0, 2);

    // Reset during the right word drops the frame, then resync.
    do_reset(2);
    p0 = pulses;
    send_word(1'b1, 0, 2);
    send_word(1'b0, 32'b11001, 5);
    tick(1'b1, carry);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    do_reset(2);
    check("midrst_nopulse", pulses - p0, 0);
    p0 = pulses;
    send_word(1'b1, 0, 3);
    send_word(1'b0, 32'b10011, 5);
    send_word(1'b1, 32'b01010, 5);
    send_word(1'b0, 0, 2);
    check("resync_pulses", pulses - p0, 1);
    check("resync_l", got_l, 5'b10011);
    check("resync_r", got_r, 5'b01010);

    // Random words and slot lengths.
    do_reset(2);
    send_word(1'b1, $urandom, $urandom_range(1, 3));
    for (int k = 0; k < 40; k++) send_word(k[0], $urandom, $urandom_range(1, 8));

    repeat (3) @(negedge sck);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
